motor_pwm_mc: RTL and testbench
===============================

Name: motor_pwm_mc

Overview:
- Parametrised, multi-channel successor to the two-channel motor PWM controller.
- Converts signed per-channel speed commands into fwd/rev PWM pairs for H-bridge drivers, with selectable width and channel count.
- Adds behaviour the earlier block lacks: period-boundary duty update, dead-time on direction reversal, a global coast enable and a period-start strobe.
- Sits between the PID/steering math and the motor driver pins.

Parameters:
- NUM_CH, 2, number of motor channels.
- CMD_W, 11, signed command width; the PWM period is 2^(CMD_W-1) clocks.
- DEAD_CYC, 16, clocks both outputs are held low on a fwd<->rev reversal; 0 disables the DEAD state; must be < 2^(CMD_W-1).
- RAMP_STEP, 8, maximum change in the applied command magnitude per period (used only with MOTOR_PWM_RAMP_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- cmd  in  NUM_CH*CMD_W  packed signed commands; channel i occupies bits [i*CMD_W +: CMD_W].
- cmd_vld  in  1  latches all of cmd into the target registers.
- en  in  1  global enable; 0 = coast.
- fwd  out  NUM_CH  forward PWM, one bit per channel.
- rev  out  NUM_CH  reverse PWM, one bit per channel.
- period_start  out  1  one-cycle pulse in the first cycle of each PWM period.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - cnt=0; target, applied and dead counters = 0.
  - All channels enter COAST.
  - fwd=0, rev=0, period_start=0.
- cnt:
  - Width CMD_W-1; free-running; increments every clock and wraps from 2^(CMD_W-1)-1 to 0.
  - The boundary edge is the clock edge at which cnt wraps.
  - period_start is registered and is 1 in the cycle where cnt==0.
- Command capture:
  - cmd_vld=1 loads target[i] = cmd slice on that edge. It may arrive in any cycle.
  - Targets are only transferred into applied[i] on a boundary edge. Duty therefore never changes mid-period.
  - If cmd_vld coincides with the boundary edge, the applied value takes the old target; the new command becomes effective at the following boundary.
- Magnitude: mag = |applied|, saturated to 2^(CMD_W-1)-1. The most-negative command (e.g. -1024) gives mag 1023.
- Per-channel FSM, evaluated on the boundary edge:
  - COAST: en=0. Outputs 0/0.
  - FWD: applied>0. fwd = (cnt<mag), rev = 0.
  - REV: applied<0. rev = (cnt<mag), fwd = 0.
  - BRAKE: applied==0. fwd=1, rev=1.
  - DEAD: both outputs 0; dead_cnt counts down from DEAD_CYC.
- Transitions:
  - FWD->REV or REV->FWD goes through DEAD. When dead_cnt reaches 0, the channel enters the new direction mid-period and resumes compare against the running cnt.
  - All other transitions (COAST, BRAKE, same direction) are direct at the boundary.
  - A target change while in DEAD is deferred to the next boundary. DEAD always completes.
- Output latency: fwd/rev are registered; each is a function of cnt, state and mag from the previous cycle (1 clock latency).
- en=0 (any cycle):
  - On the next edge, all channels go to COAST, outputs go to 0, and applied and dead_cnt are cleared.
  - On en=1, the channel stays in COAST until the next boundary, then takes the normal path from the current target. COAST->REV/FWD needs no dead time.
- Reset mid-period or mid-DEAD: returns to the full reset state on that edge.

Optional Feature:
- MOTOR_PWM_RAMP_EN defined:
  - At each boundary, applied[i] moves toward target[i] by at most RAMP_STEP, in signed arithmetic, and lands exactly on target when within the step.
  - A sign reversal therefore ramps through smaller magnitudes. Whenever applied changes sign between consecutive boundaries, the DEAD rule still applies.
  - BRAKE is entered only if applied lands exactly on 0.
- MOTOR_PWM_RAMP_EN undefined: applied = target at every boundary, and RAMP_STEP is ignored.

Test Plan:
- Defaults, both channels cmd=124, cmd_vld pulse:
  - After the next boundary: fwd high for exactly 124 of every 1024 clocks, rev=0 on both.
  - period_start pulses every 1024 clocks.
- ch0=+124, ch1=-124: ch0 fwd PWM 124/1024, rev0=0; ch1 rev PWM 124/1024, fwd1=0.
- Both cmd=0: after the boundary, fwd=rev=1 continuously on both channels (BRAKE).
- ch0 +500 then -500, steady state:
  - At the boundary edge, fwd0 and rev0 are both 0 for exactly 16 clocks.
  - rev0 is then high until cnt=500 in that period; no cycle has fwd0=rev0=1.
- cmd=-1024: rev high 1023 of 1024 clocks. cmd_vld asserted on the boundary edge: the old value persists one extra full period.
- en dropped mid-period: outputs 0 on the next clock. en re-raised: outputs stay 0 until the next boundary, then resume the target PWM.
- With MOTOR_PWM_RAMP_EN and 0 -> +40: applied duty is 8, 16, 24, 32, 40 over 5 successive periods.

Source files
------------

// File: rtl/motor_pwm_mc.sv
// motor_pwm_mc: multi-channel signed-command to fwd/rev H-bridge PWM with period-boundary
// duty update, reversal dead time, coast enable and period-start strobe. Optional macro: MOTOR_PWM_RAMP_EN.
module motor_pwm_mc #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CMD_W     = 11,
  parameter int unsigned DEAD_CYC  = 16,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*CMD_W-1:0] cmd,
  input  logic                    cmd_vld,
  input  logic                    en,
  output logic [NUM_CH-1:0]       fwd,
  output logic [NUM_CH-1:0]       rev,
  output logic                    period_start
);

  localparam int unsigned CNT_W = CMD_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC);
  localparam logic [CMD_W-1:0] CMD_MIN   = {1'b1, {CNT_W{1'b0}}};
  localparam logic             DEAD_EN   = (DEAD_CYC != 0);

  typedef enum logic [2:0] {
    ST_COAST,
    ST_FWD,
    ST_REV,
    ST_BRAKE,
    ST_DEAD
  } state_e;

  typedef logic signed [CMD_W-1:0] cmd_t;

  logic [CNT_W-1:0]  cnt_q;
  logic              period_start_q;
  logic [NUM_CH-1:0] fwd_q;
  logic [NUM_CH-1:0] rev_q;
  cmd_t              target_q  [NUM_CH];
  cmd_t              applied_q [NUM_CH];
  cmd_t              applied_d [NUM_CH];
  logic [CNT_W-1:0]  dead_q    [NUM_CH];
  logic [CNT_W-1:0]  mag_c     [NUM_CH];
  state_e            state_q   [NUM_CH];
  logic              boundary_c;

  assign boundary_c   = (cnt_q == CNT_MAX);
  assign fwd          = fwd_q;
  assign rev          = rev_q;
  assign period_start = period_start_q;

  // Drive direction implied by a signed command; zero means brake.
  function automatic state_e dir_of(input cmd_t v);
    if (v == '0) return ST_BRAKE;
    return v[CMD_W-1] ? ST_REV : ST_FWD;
  endfunction

  function automatic logic is_reversal(input state_e s, input cmd_t v);
    return ((s == ST_FWD) && v[CMD_W-1]) ||
           ((s == ST_REV) && !v[CMD_W-1] && (v != '0));
  endfunction

`ifdef MOTOR_PWM_RAMP_EN
  localparam logic signed [CMD_W:0] STEP = (CMD_W+1)'(RAMP_STEP);
  logic signed [CMD_W:0] diff_c [NUM_CH];

  // Slew applied toward target by at most STEP, landing exactly when close enough.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      diff_c[i] = (CMD_W+1)'(target_q[i]) - (CMD_W+1)'(applied_q[i]);
      if (diff_c[i] > STEP) begin
        applied_d[i] = CMD_W'((CMD_W+1)'(applied_q[i]) + STEP);
      end else if (diff_c[i] < -STEP) begin
        applied_d[i] = CMD_W'((CMD_W+1)'(applied_q[i]) - STEP);
      end else begin
        applied_d[i] = target_q[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      applied_d[i] = target_q[i];
    end
  end
`endif

  // |applied| saturated so the most-negative command maps to full scale.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!applied_q[i][CMD_W-1]) begin
        mag_c[i] = CNT_W'(applied_q[i]);
      end else if (applied_q[i] == cmd_t'(CMD_MIN)) begin
        mag_c[i] = '1;
      end else begin
        mag_c[i] = CNT_W'(-applied_q[i]);
      end
    end
  end

  // Period counter, command capture, per-channel FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      fwd_q          <= '0;
      rev_q          <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i]  <= '0;
        applied_q[i] <= '0;
        dead_q[i]    <= '0;
        state_q[i]   <= ST_COAST;
      end
    end else begin
      cnt_q          <= cnt_q + 1'b1;
      period_start_q <= boundary_c;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cmd_vld) target_q[i] <= cmd[i*CMD_W +: CMD_W];
        if (!en) begin
          fwd_q[i]     <= 1'b0;
          rev_q[i]     <= 1'b0;
          applied_q[i] <= '0;
          dead_q[i]    <= '0;
          state_q[i]   <= ST_COAST;
        end else begin
          case (state_q[i])
            ST_FWD: begin
              fwd_q[i] <= (cnt_q < mag_c[i]);
              rev_q[i] <= 1'b0;
            end
            ST_REV: begin
              fwd_q[i] <= 1'b0;
              rev_q[i] <= (cnt_q < mag_c[i]);
            end
            ST_BRAKE: begin
              fwd_q[i] <= 1'b1;
              rev_q[i] <= 1'b1;
            end
            default: begin
              fwd_q[i] <= 1'b0;
              rev_q[i] <= 1'b0;
            end
          endcase
          // DEAD never spans a boundary because DEAD_CYC is shorter than a period.
          if (boundary_c) begin
            applied_q[i] <= applied_d[i];
            if (DEAD_EN && is_reversal(state_q[i], applied_d[i])) begin
              state_q[i] <= ST_DEAD;
              dead_q[i]  <= DEAD_LOAD;
            end else begin
              state_q[i] <= dir_of(applied_d[i]);
            end
          end else if (state_q[i] == ST_DEAD) begin
            if (dead_q[i] <= CNT_W'(1)) begin
              dead_q[i]  <= '0;
              state_q[i] <= dir_of(applied_q[i]);
            end else begin
              dead_q[i] <= dead_q[i] - 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm_mc.sv
// Scoreboard bench for motor_pwm_mc: period-level reference model plus directed duty-count checks.
module tb_motor_pwm_mc;

  localparam int NUM_CH = 2;
  localparam int CMD_W  = 11;
  localparam int PER    = 1024;
  localparam int DEAD   = 16;
  localparam int MAXMAG = 1023;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*CMD_W-1:0] cmd = '0;
  logic                    cmd_vld = 1'b0;
  logic                    en = 1'b0;
  logic [NUM_CH-1:0]       fwd;
  logic [NUM_CH-1:0]       rev;
  logic                    period_start;

  int checks = 0;
  int errors = 0;

  motor_pwm_mc dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_vld(cmd_vld), .en(en),
    .fwd(fwd), .rev(rev), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] f;
    logic [NUM_CH-1:0] r;
    logic              ps;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: per-period plan (applied value, direction, reversal flag, coast flag).
  int m_cnt = 0;
  int m_tgt [NUM_CH];
  int m_app [NUM_CH];
  int m_dir [NUM_CH];
  bit m_coast [NUM_CH];
  bit m_dead [NUM_CH];

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int mag_of(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return (m > MAXMAG) ? MAXMAG : m;
  endfunction

  function automatic int step_toward(input int a, input int t);
    int step;
`ifdef MOTOR_PWM_RAMP_EN
    step = 8;
`else
    step = 1 << 30;
`endif
    if (t > a) return (t - a > step) ? a + step : t;
    if (t < a) return (a - t > step) ? a - step : t;
    return t;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int nxt;
    logic signed [CMD_W-1:0] s;
    e = '0;
    if (!rst_n) begin
      m_cnt = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_tgt[c] = 0; m_app[c] = 0; m_dir[c] = 0; m_coast[c] = 1'b1; m_dead[c] = 1'b0;
      end
    end else begin
      e.ps = (m_cnt == PER - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (!en) begin
          m_coast[c] = 1'b1; m_app[c] = 0; m_dead[c] = 1'b0;
        end else if (!m_coast[c] && !(m_dead[c] && m_cnt < DEAD)) begin
          if (m_dir[c] == 0) begin
            e.f[c] = 1'b1; e.r[c] = 1'b1;
          end else if (m_dir[c] > 0) begin
            e.f[c] = (m_cnt < mag_of(m_app[c]));
          end else begin
            e.r[c] = (m_cnt < mag_of(m_app[c]));
          end
        end
        if (en && m_cnt == PER - 1) begin
          nxt = step_toward(m_app[c], m_tgt[c]);
          m_dead[c]  = !m_coast[c] && (m_dir[c] * sgn(nxt) < 0) && (DEAD > 0);
          m_dir[c]   = sgn(nxt);
          m_app[c]   = nxt;
          m_coast[c] = 1'b0;
        end
      end
      if (cmd_vld) begin
        for (int c = 0; c < NUM_CH; c++) begin
          s = cmd[c*CMD_W +: CMD_W];
          m_tgt[c] = int'(s);
        end
      end
      m_cnt = (m_cnt + 1) % PER;
    end
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a new output word; compare away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (fwd !== e.f || rev !== e.r || period_start !== e.ps) begin
        errors++;
        if (errors <= 20)
          $display("FAIL scoreboard t=%0t got fwd=%b rev=%b ps=%b want fwd=%b rev=%b ps=%b",
                   $time, fwd, rev, period_start, e.f, e.r, e.ps);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NUM_CH*CMD_W-1:0] pack(input int c0, input int c1);
    logic [NUM_CH*CMD_W-1:0] v;
    v[0 +: CMD_W]     = CMD_W'(c0);
    v[CMD_W +: CMD_W] = CMD_W'(c1);
    return v;
  endfunction

  task automatic set_cmd(input int c0, input int c1);
    tick(2);
    cmd = pack(c0, c1);
    cmd_vld = 1'b1;
    tick(1);
    cmd_vld = 1'b0;
    tick(2);
  endtask

  task automatic wait_ps(input string nm);
    int g;
    g = 0;
    @(negedge clk);
    while (period_start !== 1'b1 && g < 2 * PER + 8) begin
      @(negedge clk);
      g++;
    end
    if (period_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: no period_start within %0d cycles", nm, g);
    end
  endtask

  task automatic skip_period();
    wait_ps("skip");
    repeat (PER - 1) @(negedge clk);
  endtask

  // Count high cycles per output over one full period starting at period_start.
  task automatic check_duty(input string nm, input int ef0, input int er0, input int ef1, input int er1);
    int nf0, nr0, nf1, nr1;
    nf0 = 0; nr0 = 0; nf1 = 0; nr1 = 0;
    wait_ps(nm);
    for (int i = 0; i < PER; i++) begin
      nf0 += int'(fwd[0]); nr0 += int'(rev[0]);
      nf1 += int'(fwd[1]); nr1 += int'(rev[1]);
      if (i < PER - 1) @(negedge clk);
    end
    checks++;
    if (nf0 != ef0 || nr0 != er0 || nf1 != ef1 || nr1 != er1) begin
      errors++;
      $display("FAIL %s: got f0=%0d r0=%0d f1=%0d r1=%0d want f0=%0d r0=%0d f1=%0d r1=%0d",
               nm, nf0, nr0, nf1, nr1, ef0, er0, ef1, er1);
    end
  endtask

  task automatic check_gap();
    int n;
    wait_ps("gap");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 3 * PER);
    checks++;
    if (n != PER) begin
      errors++;
      $display("FAIL ps_gap: got %0d cycles want %0d", n, PER);
    end
  endtask

  task automatic check_out(input string nm, input logic [NUM_CH-1:0] ef, input logic [NUM_CH-1:0] er);
    checks++;
    if (fwd !== ef || rev !== er) begin
      errors++;
      $display("FAIL %s: got fwd=%b rev=%b want fwd=%b rev=%b", nm, fwd, rev, ef, er);
    end
  endtask

  initial begin
    en = 1'b1;
    tick(2);
    checks++;
    if (fwd !== '0 || rev !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got fwd=%b rev=%b ps=%b want 0", fwd, rev, period_start);
    end
    tick(1);
    rst_n = 1'b1;

`ifdef MOTOR_PWM_RAMP_EN
    set_cmd(40, -40);
    for (int p = 1; p <= 5; p++) check_duty("ramp", 8 * p, 0, 0, 8 * p);
`else
    set_cmd(124, 124);
    check_duty("fwd124", 124, 0, 124, 0);
    check_gap();

    set_cmd(124, -124);
    check_duty("mixed_dead", 124, 0, 0, 124 - DEAD);
    check_duty("mixed", 124, 0, 0, 124);

    set_cmd(0, 0);
    check_duty("brake_first", 1023, 1023, 1023, 1023);
    check_duty("brake", PER, PER, PER, PER);

    set_cmd(500, 0);
    skip_period();
    check_duty("fwd500", 500, 0, PER, PER);
    set_cmd(-500, 0);
    check_duty("rev_dead", 0, 500 - DEAD, PER, PER);
    check_duty("rev500", 0, 500, PER, PER);

    set_cmd(-1024, 0);
    check_duty("neg_full", 0, 1023, PER, PER);
    wait_ps("align");
    tick(PER - 1);
    cmd = pack(-300, 0);
    cmd_vld = 1'b1;
    tick(1);
    cmd_vld = 1'b0;
    check_duty("late_vld_old", 0, 1023, PER, PER);
    check_duty("late_vld_new", 0, 300, PER, PER);

    set_cmd(200, -200);
    skip_period();
    check_duty("steady200", 200, 0, 0, 200);
    tick(100);
    check_out("pre_drop", 2'b01, 2'b10);
    en = 1'b0;
    tick(1);
    check_out("en_drop", 2'b00, 2'b00);
    tick(50);
    en = 1'b1;
    tick(5);
    check_out("coast_hold", 2'b00, 2'b00);
    check_duty("resume200", 200, 0, 0, 200);
`endif

    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        cmd = pack(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
        if (r < 10) cmd = pack(-1024, 0);
        cmd_vld = 1'b1;
        tick(1);
        cmd_vld = 1'b0;
      end else if (r < 82) begin
        en = ~en;
        tick(1);
      end else begin
        rst_n = 1'b0;
        tick(int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end
      tick(int'($urandom_range(1, 1500)));
    end
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
